// File: rtl/data_mem_bhw_if.sv
// MEM-stage data memory bus: load/store request, registered load result and status.
interface data_mem_bhw_if #(
  parameter int unsigned B = 32,
  parameter int unsigned W = 5
);
  localparam int unsigned NB  = B / 8;
  localparam int unsigned OFF = $clog2(NB);
  localparam int unsigned AW  = W + OFF;

  logic          i_mem_read;
  logic          i_mem_write;
  logic [1:0]    i_size;
  logic          i_unsigned;
  logic [AW-1:0] i_addr;
  logic [B-1:0]  i_data;
  logic [B-1:0]  o_data;
  logic          o_ready;
  logic          o_misaligned;

  modport master (
    output i_mem_read, i_mem_write, i_size, i_unsigned, i_addr, i_data,
    input  o_data, o_ready, o_misaligned
  );

  modport slave (
    input  i_mem_read, i_mem_write, i_size, i_unsigned, i_addr, i_data,
    output o_data, o_ready, o_misaligned
  );
endinterface

// File: rtl/data_mem_bhw.sv
// Byte-addressed data memory with lane stores, extending loads and a post-reset clear sequencer.
// Optional debug read port enabled by defining DATA_MEM_DEBUG_PORT_EN.
module data_mem_bhw #(
  parameter int unsigned B = 32,
  parameter int unsigned W = 5
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  data_mem_bhw_if.slave  bus
`ifdef DATA_MEM_DEBUG_PORT_EN
  ,
  input  logic [W-1:0]   i_dbg_addr,
  output logic [B-1:0]   o_dbg_data
`endif
);
  localparam int unsigned NB    = B / 8;
  localparam int unsigned OFF   = $clog2(NB);
  localparam int unsigned AW    = W + OFF;
  localparam int unsigned DEPTH = 2 ** W;
  localparam int unsigned SHW   = OFF + 3;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [B-1:0]   data_q, data_d;
  logic           mis_q, mis_d;
  logic           ready_q, ready_d;

  logic [B-1:0]   mem [DEPTH];

  logic [W-1:0]   idx;
  logic [OFF-1:0] off;
  logic [SHW-1:0] shamt;
  logic           aligned;
  logic [NB-1:0]  size_be;
  logic [B-1:0]   size_mask;
  logic           sign_bit;
  logic [B-1:0]   rd_shift;
  logic [B-1:0]   load_val;

  logic           wr_en;
  logic [W-1:0]   wr_idx;
  logic [NB-1:0]  wr_be;
  logic [B-1:0]   wr_data;

  assign idx      = bus.i_addr[AW-1:OFF];
  assign off      = bus.i_addr[OFF-1:0];
  assign shamt    = {off, 3'b000};
  assign rd_shift = mem[idx] >> shamt;

  // Size decode: lane mask, value mask and alignment check.
  always_comb begin
    size_be   = '1;
    size_mask = '1;
    sign_bit  = 1'b0;
    aligned   = 1'b0;
    case (bus.i_size)
      2'b00: begin
        size_be   = NB'(1);
        size_mask = B'(8'hFF);
        sign_bit  = rd_shift[7];
        aligned   = 1'b1;
      end
      2'b01: begin
        size_be   = NB'(3);
        size_mask = B'(16'hFFFF);
        sign_bit  = rd_shift[15];
        aligned   = (off[0] == 1'b0);
      end
      2'b10: begin
        size_be   = NB'(15);
        size_mask = B'(32'hFFFF_FFFF);
        sign_bit  = rd_shift[31];
        aligned   = (off[1:0] == 2'b00);
      end
      default: begin
        size_be   = '1;
        size_mask = '1;
        sign_bit  = 1'b0;
        aligned   = (B > 32) && (off == '0);
      end
    endcase
  end

  assign load_val = (rd_shift & size_mask) |
                    ((sign_bit && !bus.i_unsigned) ? ~size_mask : '0);

  // Next-state and access control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = '0;
    mis_d   = 1'b0;
    ready_d = ready_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    wr_be   = '1;
    wr_data = '0;
    case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + W'(1);
        if (cnt_q == W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        ready_d = 1'b1;
        if (bus.i_mem_read || bus.i_mem_write) begin
          if (!aligned) begin
            mis_d = 1'b1;
          end else if (bus.i_mem_write) begin
            wr_en   = 1'b1;
            wr_idx  = idx;
            wr_be   = size_be << off;
            wr_data = bus.i_data << shamt;
          end else begin
            data_d = load_val;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
      ready_q <= ready_d;
    end
  end

  // Array has no reset; the clear sequencer zeroes it instead.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

`ifdef DATA_MEM_DEBUG_PORT_EN
  logic [B-1:0] dbg_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) dbg_q <= '0;
    else            dbg_q <= (state_q == ST_IDLE) ? mem[i_dbg_addr] : '0;
  end

  assign o_dbg_data = dbg_q;
`endif

  assign bus.o_data       = data_q;
  assign bus.o_misaligned = mis_q;
  assign bus.o_ready      = ready_q;
endmodule

// File: tb/tb_data_mem_bhw.sv
// Scoreboard bench for data_mem_bhw: byte-array reference model feeds an expectation queue.
module tb_data_mem_bhw;
  localparam int unsigned B     = 32;
  localparam int unsigned W     = 5;
  localparam int unsigned NB    = B / 8;
  localparam int unsigned DEPTH = 2 ** W;
  localparam int unsigned AW    = W + $clog2(NB);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_bhw_if #(.B(B), .W(W)) bus ();

`ifdef DATA_MEM_DEBUG_PORT_EN
  logic [W-1:0] dbg_addr = '0;
  logic [B-1:0] dbg_data;
  data_mem_bhw #(.B(B), .W(W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );
`else
  data_mem_bhw #(.B(B), .W(W)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
`endif

  typedef struct {
    logic [B-1:0] data;
    logic         mis;
    logic         rdy;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mbytes [DEPTH*NB];
  int         clr_cycles = 0;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return (B > 32) ? int'(NB) : 0;
    endcase
  endfunction

  // Reference model: what the memory must present after this edge.
  always @(posedge clk) begin : model
    exp_t         e;
    int           n, a;
    logic [B-1:0] v;
    e.data = '0; e.mis = 1'b0; e.rdy = 1'b0;
    if (!rst_n) begin
      clr_cycles = 0;
    end else if (clr_cycles < int'(DEPTH)) begin
      clr_cycles++;
      if (clr_cycles == int'(DEPTH)) begin
        e.rdy = 1'b1;
        foreach (mbytes[i]) mbytes[i] = 8'h00;
      end
    end else begin
      e.rdy = 1'b1;
      if (bus.i_mem_read || bus.i_mem_write) begin
        n = nbytes(bus.i_size);
        a = int'(bus.i_addr);
        if (n == 0 || (a % n) != 0) begin
          e.mis = 1'b1;
        end else if (bus.i_mem_write) begin
          for (int k = 0; k < n; k++) mbytes[a+k] = bus.i_data[8*k +: 8];
        end else begin
          v = '0;
          for (int k = 0; k < n; k++) v[8*k +: 8] = mbytes[a+k];
          if (!bus.i_unsigned && v[8*n-1])
            for (int j = 8*n; j < int'(B); j++) v[j] = 1'b1;
          e.data = v;
        end
      end
    end
    sb.push_back(e);
  end

  task automatic chk(input string nm, input logic [B-1:0] act, input logic [B-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compare registered outputs mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!rst_n) begin
        e.data = '0; e.mis = 1'b0; e.rdy = 1'b0;
      end
      chk("o_data", bus.o_data, e.data);
      chk("o_misaligned", B'(bus.o_misaligned), B'(e.mis));
      chk("o_ready", B'(bus.o_ready), B'(e.rdy));
    end
  end

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                    input logic uns, input logic [AW-1:0] a, input logic [B-1:0] d);
    @(posedge clk);
    #1;
    bus.i_mem_read  = rd;
    bus.i_mem_write = wr;
    bus.i_size      = sz;
    bus.i_unsigned  = uns;
    bus.i_addr      = a;
    bus.i_data      = d;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
  endtask

  task automatic set_reset(input logic v);
    @(posedge clk);
    #1;
    rst_n = v;
  endtask

  task automatic rand_op();
    int           r, n;
    logic [AW-1:0] a;
    logic [1:0]   sz;
    r  = $urandom_range(0, 7);
    sz = 2'($urandom_range(0, 3));
    a  = AW'($urandom);
    n  = nbytes(sz);
    if (n > 0 && $urandom_range(0, 3) != 0) a = a & ~AW'(n - 1);
    op(r <= 2 || r == 6, (r >= 3 && r <= 5) || r == 6, sz, 1'($urandom), a, B'($urandom));
  endtask

  initial begin
    bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0; bus.i_size = 2'b00;
    bus.i_unsigned = 1'b0; bus.i_addr = '0; bus.i_data = '0;
    repeat (3) @(posedge clk);
    set_reset(1'b1);
    // Traffic during the clear must have no effect.
    for (int i = 0; i < int'(DEPTH) - 1; i++) rand_op();
    op(1'b1, 1'b0, 2'b10, 1'b0, AW'(7'h7C), '0);
    op(1'b1, 1'b0, 2'b10, 1'b0, AW'(7'h00), '0);

    op(1'b0, 1'b1, 2'b10, 1'b0, AW'(7'h08), 32'hDEADBEEF);
    for (int i = 8; i < 12; i++) op(1'b1, 1'b0, 2'b00, 1'b0, AW'(i), '0);
    op(1'b1, 1'b0, 2'b00, 1'b1, AW'(7'h0B), '0);
    op(1'b0, 1'b1, 2'b10, 1'b0, AW'(7'h0C), 32'h11223344);
    op(1'b0, 1'b1, 2'b01, 1'b0, AW'(7'h0E), 32'hFFFF8001);
    op(1'b1, 1'b0, 2'b10, 1'b0, AW'(7'h0C), '0);
    op(1'b1, 1'b0, 2'b01, 1'b0, AW'(7'h0E), '0);
    op(1'b1, 1'b0, 2'b01, 1'b1, AW'(7'h0E), '0);
    op(1'b0, 1'b1, 2'b10, 1'b0, AW'(7'h04), 32'hCAFEF00D);
    op(1'b0, 1'b1, 2'b10, 1'b0, AW'(7'h06), 32'h12345678);
    op(1'b1, 1'b0, 2'b01, 1'b0, AW'(7'h03), '0);
    op(1'b1, 1'b0, 2'b10, 1'b0, AW'(7'h04), '0);
    op(1'b1, 1'b0, 2'b11, 1'b0, AW'(7'h20), '0);
    op(1'b1, 1'b1, 2'b10, 1'b0, AW'(7'h10), 32'h55AA55AA);
    op(1'b1, 1'b0, 2'b10, 1'b0, AW'(7'h10), '0);
    idle();

    // Reset in IDLE, then again mid-clear at counter 10.
    set_reset(1'b0);
    set_reset(1'b1);
    for (int i = 0; i < 9; i++) rand_op();
    set_reset(1'b0);
    idle();
    set_reset(1'b1);
    for (int i = 0; i < int'(DEPTH) - 1; i++) rand_op();
    op(1'b1, 1'b0, 2'b10, 1'b0, AW'(7'h7C), '0);
    op(1'b1, 1'b0, 2'b10, 1'b0, AW'(7'h10), '0);

    for (int i = 0; i < 600; i++) rand_op();
    repeat (4) idle();
    @(negedge clk);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
